// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared mode encoding for the multi-channel countdown timer
package counter_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_OFF      = 2'b00,
      MODE_ONESHOT  = 2'b01,
      MODE_PERIODIC = 2'b10,
      MODE_SQUARE   = 2'b11
   } mode_t;

   // Extracts the mode field of channel idx from a packed control word.
   function automatic mode_t ctrl_mode(input logic [15:0] ctrl, input int idx);
      return mode_t'(ctrl[idx*MODE_W +: MODE_W]);
   endfunction

endpackage

// File: rtl/counter_chan.sv
// rtl/counter_chan.sv - one countdown channel: tick edge detect, load/count registers, irq line
module counter_chan
   import counter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  mode_t            mode,
   input  logic             load_we,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             irq
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   logic             tick_d;
   logic [WIDTH-1:0] load;
   logic             cnt_evt;
   logic             can_count;

   assign cnt_evt   = tick & ~tick_d;
   assign can_count = cnt_evt && (mode != MODE_OFF) && (load != '0) && (count != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_d <= 1'b0;
         load   <= '0;
         count  <= '0;
         irq    <= 1'b0;
      end else begin
         tick_d <= tick;
         // A load write takes priority; any coincident count event is dropped.
         if (load_we) begin
            load  <= load_val;
            count <= load_val;
            irq   <= 1'b0;
         end else begin
            // Periodic irq is a single-cycle strobe; other modes hold their level.
            if (mode == MODE_PERIODIC) begin
               irq <= 1'b0;
            end
            if (can_count) begin
               if (count == ONE) begin
                  unique case (mode)
                     MODE_ONESHOT: begin
                        count <= '0;
                        irq   <= 1'b1;
                     end
                     MODE_PERIODIC: begin
                        count <= load;
                        irq   <= 1'b1;
                     end
                     MODE_SQUARE: begin
                        count <= load;
                        irq   <= ~irq;
                     end
                     default: begin
                        count <= count;
                     end
                  endcase
               end else begin
                  count <= count - ONE;
               end
            end
         end
      end
   end

endmodule

// File: rtl/counter_nch.sv
// rtl/counter_nch.sv - NCH-channel countdown timer: control register, write decode, readback mux
module counter_nch
   import counter_pkg::*;
#(
   parameter int NCH   = 3,
   parameter int WIDTH = 32,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   tick,
   input  logic             counter_we,
   input  logic [SEL_W-1:0] counter_sel,
   input  logic [WIDTH-1:0] counter_val,
   output logic [WIDTH-1:0] counter_out,
   output logic [NCH-1:0]   counter_irq
);

   localparam int               CTRL_W   = MODE_W * NCH;
   localparam logic [SEL_W-1:0] CTRL_SEL = SEL_W'(NCH);

   logic [CTRL_W-1:0] ctrl;
   logic [WIDTH-1:0]  count_arr [NCH];
   logic [WIDTH-1:0]  rd_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl <= '0;
      end else if (counter_we && (counter_sel == CTRL_SEL)) begin
         ctrl <= counter_val[CTRL_W-1:0];
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      logic load_we;
      assign load_we = counter_we && (counter_sel == SEL_W'(i));

      counter_chan #(
         .WIDTH (WIDTH)
      ) u_chan (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick[i]),
         .mode     (mode_t'(ctrl[i*MODE_W +: MODE_W])),
         .load_we  (load_we),
         .load_val (counter_val),
         .count    (count_arr[i]),
         .irq      (counter_irq[i])
      );
   end

   // Selects beyond the control register read back as zero.
   always_comb begin
      rd_val = '0;
      for (int i = 0; i < NCH; i++) begin
         if (counter_sel == SEL_W'(i)) begin
            rd_val = count_arr[i];
         end
      end
      if (counter_sel == CTRL_SEL) begin
         rd_val = WIDTH'(ctrl);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         counter_out <= '0;
      end else begin
         counter_out <= rd_val;
      end
   end

endmodule
